reg_file_lr: RTL and testbench

Architectural register file for the multi-cycle processor datapath, directly downstream of the controller FSM. Holds general registers R0–R6, the program counter (R7) and the link register, and consumes the controller's write strobes: RegWrite, PCWrite, LRWrite and WriteSelect. Provides two combinational read ports to the ALU-operand stage, plus the current PC and LR for the address mux and branch logic.

---
 rtl/reg_file_lr.sv | 124 ++++++++++++
 tb/tb_reg_file_lr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_lr.sv
// reg_file_lr: architectural register file (R0-R6 GPRs, R7 = PC, link register)
// for the multi-cycle datapath. Two combinational read ports, one write port.
// Optional macro LR_STACK_EN turns LR into a 4-entry circular return-address
// stack; with the macro undefined LR is a single register.
module reg_file_lr #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  RegWrite,
   input  logic                  PCWrite,
   input  logic                  LRWrite,
   input  logic                  WriteSelect,
   input  logic [2:0]            A1,
   input  logic [2:0]            A2,
   input  logic [2:0]            A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   input  logic [DATA_WIDTH-1:0] PCIn,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] LR
);

   localparam int unsigned NUM_GPR = 7;
   localparam logic [2:0]  PC_ADDR = 3'd7;

   logic [DATA_WIDTH-1:0] r_gpr [0:NUM_GPR-1];
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_lr_top;
   logic [DATA_WIDTH-1:0] w_pc_next;
   logic [DATA_WIDTH-1:0] w_rd1;
   logic [DATA_WIDTH-1:0] w_rd2;
   logic                  w_r7_write;
   logic                  w_pc_load;
   logic                  w_ret_sel;

   // WriteSelect only matters when PCWrite is also asserted
   assign w_r7_write = RegWrite && (A3 == PC_ADDR);
   assign w_pc_load  = PCWrite || w_r7_write;
   assign w_ret_sel  = PCWrite && WriteSelect;

   // PC source priority: LR/top-of-stack, then WD3 for an R7 write, then PCIn
   always_comb begin
      w_pc_next = PCIn;
      if (w_ret_sel)
         w_pc_next = w_lr_top;
      else if (w_r7_write)
         w_pc_next = WD3;
   end

   // Read ports: address 7 returns the PC as it stood before this edge
   always_comb begin
      w_rd1 = r_pc;
      w_rd2 = r_pc;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (A1 == 3'(i)) w_rd1 = r_gpr[i];
         if (A2 == 3'(i)) w_rd2 = r_gpr[i];
      end
   end

   // General registers; R0 is ordinary storage
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_GPR; i++) r_gpr[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++)
            if (RegWrite && (A3 == 3'(i))) r_gpr[i] <= WD3;
      end
   end

   // Program counter
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_pc <= '0;
      else if (w_pc_load)
         r_pc <= w_pc_next;
   end

`ifdef LR_STACK_EN
   logic [DATA_WIDTH-1:0] r_stk [0:3];
   logic [1:0]            r_top;
   logic [2:0]            r_cnt;

   assign w_lr_top = (r_cnt == 3'd0) ? '0 : r_stk[r_top];

   // Return-address stack: push old PC on LRWrite, pop on PC return;
   // push+pop swaps the top entry in place
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 4; i++) r_stk[i] <= '0;
         r_top <= 2'd0;
         r_cnt <= 3'd0;
      end else if (LRWrite && w_ret_sel) begin
         r_stk[r_top] <= r_pc;
      end else if (LRWrite) begin
         r_stk[r_top + 2'd1] <= r_pc;
         r_top <= r_top + 2'd1;
         if (r_cnt != 3'd4) r_cnt <= r_cnt + 3'd1;
      end else if (w_ret_sel && (r_cnt != 3'd0)) begin
         r_top <= r_top - 2'd1;
         r_cnt <= r_cnt - 3'd1;
      end
   end
`else
   logic [DATA_WIDTH-1:0] r_lr;

   assign w_lr_top = r_lr;

   // Single link register captures the pre-edge PC
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_lr <= '0;
      else if (LRWrite)
         r_lr <= r_pc;
   end
`endif

   assign RD1 = w_rd1;
   assign RD2 = w_rd2;
   assign PC  = r_pc;
   assign LR  = w_lr_top;

endmodule

// File: tb/tb_reg_file_lr.sv
// Directed bench for reg_file_lr; stack checks run only with LR_STACK_EN.
module tb_reg_file_lr;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       RegWrite, PCWrite, LRWrite, WriteSelect;
   logic [2:0] A1, A2, A3;
   logic [7:0] WD3, PCIn;
   logic [7:0] RD1, RD2, PC, LR;

   int n_vec = 0;
   int n_err = 0;

   reg_file_lr #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RESET(RESET), .RegWrite(RegWrite), .PCWrite(PCWrite),
      .LRWrite(LRWrite), .WriteSelect(WriteSelect), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .PCIn(PCIn), .RD1(RD1), .RD2(RD2), .PC(PC), .LR(LR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Clear strobes
   task automatic idle();
      RegWrite = 1'b0; PCWrite = 1'b0; LRWrite = 1'b0; WriteSelect = 1'b0;
   endtask

   // Advance one edge, then settle just past it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RESET = 1'b0;
      idle();
      A1 = 3'd0; A2 = 3'd0; A3 = 3'd0; WD3 = 8'h00; PCIn = 8'h00;

      // Reset held with random strobes: everything reads zero
      for (int c = 0; c < 4; c++) begin
         RegWrite = 1'($urandom); PCWrite = 1'($urandom);
         LRWrite = 1'($urandom); WriteSelect = 1'($urandom);
         A3 = 3'($urandom); WD3 = 8'($urandom); PCIn = 8'($urandom);
         tick();
      end
      chk("rst_pc", PC, 8'h00);
      chk("rst_lr", LR, 8'h00);
      for (int a = 0; a < 8; a++) begin
         A1 = 3'(a); A2 = 3'(7 - a);
         #1;
         chk("rst_rd1", RD1, 8'h00);
         chk("rst_rd2", RD2, 8'h00);
      end
      idle();
      #2 RESET = 1'b1;
      tick();

      // First PC load after reset release
      PCWrite = 1'b1; PCIn = 8'h05;
      tick();
      idle();
      chk("pc_load", PC, 8'h05);

      // GPR write: no forwarding in the write cycle
      RegWrite = 1'b1; A3 = 3'd3; WD3 = 8'hA5; A1 = 3'd3;
      #1;
      chk("rd1_old", RD1, 8'h00);
      tick();
      idle();
      chk("rd1_new", RD1, 8'hA5);

      // R0 and R6 boundaries
      RegWrite = 1'b1; A3 = 3'd0; WD3 = 8'h3C;
      tick();
      A3 = 3'd6; WD3 = 8'hC3;
      tick();
      idle();
      A1 = 3'd0; A2 = 3'd6;
      #1;
      chk("r0", RD1, 8'h3C);
      chk("r6", RD2, 8'hC3);

      // R7 write wins over PCIn
      RegWrite = 1'b1; A3 = 3'd7; WD3 = 8'h40; PCWrite = 1'b1; PCIn = 8'h11;
      tick();
      idle();
      chk("r7_pc", PC, 8'h40);
      A1 = 3'd3; A2 = 3'd7;
      #1;
      chk("r7_rd2", RD2, 8'h40);
      chk("r3_keep", RD1, 8'hA5);

      // R7 write alone loads PC
      RegWrite = 1'b1; A3 = 3'd7; WD3 = 8'h12;
      tick();
      idle();
      chk("r7_only", PC, 8'h12);

      // Link
      LRWrite = 1'b1;
      tick();
      idle();
      chk("link_lr", LR, 8'h12);
      chk("link_pc", PC, 8'h12);
      PCWrite = 1'b1; PCIn = 8'h30;
      tick();
      idle();
      chk("jmp_pc", PC, 8'h30);
      chk("jmp_lr", LR, 8'h12);

      // WriteSelect without PCWrite does nothing
      WriteSelect = 1'b1; PCIn = 8'h99;
      tick();
      idle();
      chk("ws_noop", PC, 8'h30);

      // Return from LR
      PCWrite = 1'b1; WriteSelect = 1'b1; PCIn = 8'h77;
      tick();
      idle();
      chk("ret_pc", PC, 8'h12);
`ifdef LR_STACK_EN
      chk("ret_lr", LR, 8'h00);
`else
      chk("ret_lr", LR, 8'h12);
`endif

      // Simultaneous PC load and link
      PCWrite = 1'b1; PCIn = 8'h20;
      tick();
      PCIn = 8'h21; LRWrite = 1'b1;
      tick();
      idle();
      chk("sim_pc", PC, 8'h21);
      chk("sim_lr", LR, 8'h20);

      // Reset mid-operation discards the pending writes
      RegWrite = 1'b1; A3 = 3'd1; WD3 = 8'h55; PCWrite = 1'b1; PCIn = 8'h66;
      A1 = 3'd3; A2 = 3'd0;
      RESET = 1'b0;
      #1;
      chk("mid_pc", PC, 8'h00);
      chk("mid_lr", LR, 8'h00);
      chk("mid_rd1", RD1, 8'h00);
      chk("mid_rd2", RD2, 8'h00);
      tick();
      idle();
      A1 = 3'd1;
      #1;
      chk("mid_r1", RD1, 8'h00);
      chk("mid_pc2", PC, 8'h00);
      #2 RESET = 1'b1;
      tick();

`ifdef LR_STACK_EN
      // Push 1..5 (overflows oldest), pop 5,4,3,2 then underflow
      for (int v = 1; v <= 5; v++) begin
         PCWrite = 1'b1; PCIn = 8'(v);
         tick();
         idle();
         LRWrite = 1'b1;
         tick();
         idle();
         chk("push_lr", LR, 8'(v));
      end
      for (int v = 5; v >= 2; v--) begin
         PCWrite = 1'b1; WriteSelect = 1'b1; PCIn = 8'hEE;
         tick();
         idle();
         chk("pop_pc", PC, 8'(v));
         chk("pop_lr", LR, (v == 2) ? 8'h00 : 8'(v - 1));
      end
      PCWrite = 1'b1; WriteSelect = 1'b1; PCIn = 8'hEE;
      tick();
      idle();
      chk("empty_pc", PC, 8'h00);
      chk("empty_lr", LR, 8'h00);
      // Count stayed 0: a single push must be the only visible entry
      PCWrite = 1'b1; PCIn = 8'h09;
      tick();
      idle();
      LRWrite = 1'b1;
      tick();
      idle();
      chk("re_push", LR, 8'h09);
      // Push and pop together swap the top
      PCWrite = 1'b1; PCIn = 8'h0A;
      tick();
      idle();
      PCWrite = 1'b1; WriteSelect = 1'b1; LRWrite = 1'b1; PCIn = 8'hEE;
      tick();
      idle();
      chk("swap_pc", PC, 8'h09);
      chk("swap_lr", LR, 8'h0A);
      PCWrite = 1'b1; WriteSelect = 1'b1;
      tick();
      idle();
      chk("swap_pop", PC, 8'h0A);
      chk("swap_emp", LR, 8'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
